// File: rtl/par_ser_pkg.sv
// par_ser_pkg: shared constants and types for the par_ser parallel-to-serial
// converter.
//   NUM_LANES  lanes per input word (6-parallel FIR output)
//   PHASE_W    width of the lane index presented on the serial side
//   LAST_PHASE index of the newest lane in a word
//   BUF_WORDS  depth of the ping-pong word buffer
package par_ser_pkg;

  localparam int unsigned NUM_LANES = 6;
  localparam int unsigned PHASE_W   = 3;
  localparam int unsigned BUF_WORDS = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t LAST_PHASE = phase_t'(NUM_LANES - 1);

  typedef logic [1:0] count_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_trunc.sv
// sat_trunc: combinational reduction of a signed y_out-bit sample to d_out bits.
//   din  : signed input sample, y_out bits
//   dout : signed reduced sample, d_out bits (d_out <= y_out)
// Default build wraps (keeps the low d_out bits). Defining PAR_SER_SAT_EN
// clamps to the d_out-bit signed range instead. Equal widths pass through.
module sat_trunc #(
  parameter int y_out = 20,
  parameter int d_out = 16
) (
  input  logic signed [y_out-1:0] din,
  output logic signed [d_out-1:0] dout
);

  generate
    if (d_out == y_out) begin : g_pass
      assign dout = din;
    end else begin : g_reduce
`ifdef PAR_SER_SAT_EN
      localparam logic signed [y_out-1:0] SAT_MAX =
        {{(y_out-d_out+1){1'b0}}, {(d_out-1){1'b1}}};
      localparam logic signed [y_out-1:0] SAT_MIN =
        {{(y_out-d_out+1){1'b1}}, {(d_out-1){1'b0}}};

      always_comb begin
        if (din > SAT_MAX)
          dout = SAT_MAX[d_out-1:0];
        else if (din < SAT_MIN)
          dout = SAT_MIN[d_out-1:0];
        else
          dout = din[d_out-1:0];
      end
`else
      // Wrapping discards the MSBs by design.
      logic unused_msbs;
      assign unused_msbs = ^din[y_out-1:d_out];
      assign dout = din[d_out-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/par_ser.sv
// par_ser: parallel-to-serial converter, inverse of the 6-lane front end.
// A 2-word FIFO (ping-pong) buffer accepts one 6-lane word per in_valid strobe
// and drains it one lane per accepted output beat, lane_0 first.
//   clk, rstn           clock; synchronous active-low reset
//   in_valid/in_ready   word strobe / buffer has room (count != 2)
//   lane_0..lane_5      signed y_out-bit lanes, lane_0 oldest
//   out_valid/out_ready serial handshake with backpressure
//   data_out            reduced signed d_out-bit sample
//   out_phase, out_last lane index presented / high on lane 5
//   overflow            sticky: a word arrived while the buffer was full
// Optional macro PAR_SER_SAT_EN: saturating reduction (inside sat_trunc).
module par_ser
  import par_ser_pkg::*;
#(
  parameter int y_out = 20,
  parameter int d_out = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [y_out-1:0] lane_0,
  input  logic signed [y_out-1:0] lane_1,
  input  logic signed [y_out-1:0] lane_2,
  input  logic signed [y_out-1:0] lane_3,
  input  logic signed [y_out-1:0] lane_4,
  input  logic signed [y_out-1:0] lane_5,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [d_out-1:0] data_out,
  output logic [PHASE_W-1:0]      out_phase,
  output logic                    out_last,
  output logic                    overflow
);

  logic signed [y_out-1:0] buf_mem [BUF_WORDS][NUM_LANES];

  state_t state_q, state_d;
  count_t count_q, count_d;
  logic   head_q, head_d;
  logic   tail_q, tail_d;
  phase_t phase_q, phase_d;
  logic   overflow_q, overflow_d;

  logic wr_en, xfer, pop;
  logic signed [y_out-1:0] head_sample;
  logic signed [d_out-1:0] reduced;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (state_q == ST_SHIFT);
  assign wr_en     = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (phase_q == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[tail_q][0] <= lane_0;
      buf_mem[tail_q][1] <= lane_1;
      buf_mem[tail_q][2] <= lane_2;
      buf_mem[tail_q][3] <= lane_3;
      buf_mem[tail_q][4] <= lane_4;
      buf_mem[tail_q][5] <= lane_5;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    phase_d    = phase_q;
    overflow_d = overflow_q;

    if (wr_en)
      tail_d = ~tail_q;
    // in_ready comes from the registered count, so a word arriving while
    // full is dropped even if the head word pops on this same edge.
    if (in_valid && !in_ready)
      overflow_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_en)
          state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (xfer) begin
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            head_d  = ~head_q;
            if (count_q == 2'd1 && !wr_en)
              state_d = ST_IDLE;
          end else begin
            phase_d = phase_q + phase_t'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    head_sample = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (phase_q == phase_t'(i))
        head_sample = buf_mem[head_q][i];
    end
  end

  sat_trunc #(
    .y_out(y_out),
    .d_out(d_out)
  ) u_sat_trunc (
    .din (head_sample),
    .dout(reduced)
  );

  assign data_out  = out_valid ? reduced : '0;
  assign out_phase = phase_q;
  assign out_last  = out_valid && (phase_q == LAST_PHASE);
  assign overflow  = overflow_q;

endmodule
